reg_read_pipe: RTL and testbench

- Parametrised register-read pipeline stage: multi-port register file, write-to-read bypass, operand equality compare, and an output pipeline register with stall/flush control.
- Sits between decode and execute in the processor pipeline.
- Register PC_REG (the program counter) has its own dedicated write port, updated every fetch.
- Successor to the fixed 16-bit/8-register, unregistered read stage.

---
 rtl/reg_read_pipe.sv | 102 ++++++++++
 tb/tb_reg_read_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reg_read_pipe.sv
// reg_read_pipe: register-read stage between decode and execute.
// Multi-port register file with a dedicated PC write port, write-to-read
// bypass, operand equality compare and a stall/flush output register.
// Optional build macro: REG_READ_PIPE_R0_ZERO_EN (register 0 hardwired to 0).
module reg_read_pipe #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int PC_REG   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] readAdd1,
  input  logic [ADDR_W-1:0] readAdd2,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAdd,
  input  logic [DATA_W-1:0] in,
  input  logic              writeR7,
  input  logic [DATA_W-1:0] inR7,
  output logic              out_valid,
  output logic [DATA_W-1:0] regValue1,
  output logic [DATA_W-1:0] regValue2,
  output logic              equalValue,
  output logic [DATA_W-1:0] pcValue
);

`ifdef REG_READ_PIPE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // Register 0 is only forced to zero when it is not also the PC register.
  localparam bit                R0_ACTIVE = R0_ZERO && (PC_REG != 0);
  localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(PC_REG);
  localparam logic [ADDR_W:0]   NUM_LIM   = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] arr1, arr2;
  logic [DATA_W-1:0] op1, op2;

  // Register array: PC port first so the general port overrides it on a clash;
  // addresses outside the array match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (writeR7 && (i == PC_REG)) regs[i] <= inR7;
        if (write && (writeAdd == ADDR_W'(i)) && !(R0_ACTIVE && (i == 0)))
          regs[i] <= in;
      end
    end
  end

  // Raw array read for both operand ports; out-of-range addresses give 0.
  always_comb begin
    arr1 = '0;
    arr2 = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (readAdd1 == ADDR_W'(i)) arr1 = regs[i];
      if (readAdd2 == ADDR_W'(i)) arr2 = regs[i];
    end
  end

  // Bypass selection: general write port, then PC port, then array.
  always_comb begin
    op1 = arr1;
    op2 = arr2;
    if (write && (writeAdd == readAdd1))        op1 = in;
    else if ((readAdd1 == PC_ADDR) && writeR7)  op1 = inR7;
    if (write && (writeAdd == readAdd2))        op2 = in;
    else if ((readAdd2 == PC_ADDR) && writeR7)  op2 = inR7;
    if ({1'b0, readAdd1} >= NUM_LIM)            op1 = '0;
    if ({1'b0, readAdd2} >= NUM_LIM)            op2 = '0;
    if (R0_ACTIVE && (readAdd1 == '0))          op1 = '0;
    if (R0_ACTIVE && (readAdd2 == '0))          op2 = '0;
  end

  // Output register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      regValue1  <= '0;
      regValue2  <= '0;
      equalValue <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (!stall) begin
      out_valid  <= in_valid;
      regValue1  <= op1;
      regValue2  <= op2;
      equalValue <= (op1 == op2);
    end
  end

  assign pcValue = regs[PC_REG];

endmodule

// File: tb/tb_reg_read_pipe.sv
// Directed bench for reg_read_pipe with a spec-level reference model that is
// compared against the DUT on every falling edge after the first reset.
module tb_reg_read_pipe;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int NR  = 8;
  localparam int PCR = 7;

`ifdef REG_READ_PIPE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, in_valid, stall, flush, write, writeR7;
  logic [AW-1:0] readAdd1, readAdd2, writeAdd;
  logic [DW-1:0] din, inR7;
  logic          out_valid, equalValue;
  logic [DW-1:0] regValue1, regValue2, pcValue;

  int vectors = 0;
  int miscompares = 0;

  reg_read_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .PC_REG(PCR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .readAdd1(readAdd1), .readAdd2(readAdd2), .write(write), .writeAdd(writeAdd),
    .in(din), .writeR7(writeR7), .inR7(inR7), .out_valid(out_valid),
    .regValue1(regValue1), .regValue2(regValue2), .equalValue(equalValue),
    .pcValue(pcValue)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] mRegs [NR];
  logic          mValid, mEq, modelReady;
  logic [DW-1:0] mV1, mV2;

  initial modelReady = 1'b0;

  function automatic logic [DW-1:0] mLook(input logic [AW-1:0] a);
    if (int'(a) >= NR) return '0;
    if (R0Z && PCR != 0 && a == 0) return '0;
    if (write && writeAdd == a) return din;
    if (int'(a) == PCR && writeR7) return inR7;
    return mRegs[a[2:0]];
  endfunction

  always @(posedge clk) begin
    logic [DW-1:0] l1, l2;
    if (reset) begin
      foreach (mRegs[i]) mRegs[i] = '0;
      mValid = 1'b0; mV1 = '0; mV2 = '0; mEq = 1'b0;
      modelReady = 1'b1;
    end else begin
      l1 = mLook(readAdd1);
      l2 = mLook(readAdd2);
      if (flush) mValid = 1'b0;
      else if (!stall) begin
        mValid = in_valid; mV1 = l1; mV2 = l2; mEq = (l1 == l2);
      end
      if (writeR7) mRegs[PCR] = inR7;
      if (write && int'(writeAdd) < NR && !(R0Z && PCR != 0 && writeAdd == 0))
        mRegs[writeAdd[2:0]] = din;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous model comparison on the falling edge.
  always @(negedge clk) begin
    if (modelReady) begin
      check("m_valid", {15'd0, out_valid}, {15'd0, mValid});
      check("m_v1", regValue1, mV1);
      check("m_v2", regValue2, mV2);
      check("m_eq", {15'd0, equalValue}, {15'd0, mEq});
      check("m_pc", pcValue, mRegs[PCR]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 0; writeR7 = 0; stall = 0; flush = 0; in_valid = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); write = 1; writeAdd = a; din = d; step(); write = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; stall = 0; flush = 0; write = 0; writeR7 = 0;
    readAdd1 = 0; readAdd2 = 0; writeAdd = 0; din = 0; inR7 = 0;
    step(); step();
    reset = 0;
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_v1", regValue1, 16'd0);
    check("rst_pc", pcValue, 16'd0);

    // basic write then read
    wr(3, 16'h1234);
    readAdd1 = 3; readAdd2 = 3; in_valid = 1; step();
    check("rd_v1", regValue1, 16'h1234);
    check("rd_v2", regValue2, 16'h1234);
    check("rd_eq", {15'd0, equalValue}, 16'd1);
    check("rd_valid", {15'd0, out_valid}, 16'd1);

    // bypass of same-cycle write
    wr(5, 16'h0001);
    write = 1; writeAdd = 5; din = 16'hBEEF; readAdd1 = 5; readAdd2 = 3; in_valid = 1;
    step();
    check("byp_v1", regValue1, 16'hBEEF);
    check("byp_eq", {15'd0, equalValue}, 16'd0);

    // general port beats PC port on register 7
    idle(); write = 1; writeAdd = 7; din = 16'h0100; writeR7 = 1; inR7 = 16'h0040;
    readAdd2 = 7; in_valid = 1; step();
    check("pc_clash", pcValue, 16'h0100);
    check("pc_clash_rd", regValue2, 16'h0100);
    // PC-only write: bypassed to readers, pcValue lags a cycle
    idle(); writeR7 = 1; inR7 = 16'h0042; readAdd1 = 7; in_valid = 1; #1;
    check("pc_nobyp", pcValue, 16'h0100);
    step();
    check("pc_byp_rd", regValue1, 16'h0042);
    check("pc_upd", pcValue, 16'h0042);

    // out-of-range address: write dropped, read gives 0 even with bypass match
    idle(); write = 1; writeAdd = 9; din = 16'h7777; readAdd1 = 9; readAdd2 = 1;
    in_valid = 1; step();
    check("oor_rd", regValue1, 16'h0000);

    // stall / flush
    wr(1, 16'h00FF); wr(2, 16'h00FE);
    readAdd1 = 1; readAdd2 = 2; in_valid = 1; step();
    check("ne_eq", {15'd0, equalValue}, 16'd0);
    check("ne_v2", regValue2, 16'h00FE);
    stall = 1; in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      readAdd1 = AW'(3 + k); readAdd2 = 3; step();
      check("stall_v1", regValue1, 16'h00FF);
      check("stall_valid", {15'd0, out_valid}, 16'd1);
    end
    flush = 1; step();
    check("flush_valid", {15'd0, out_valid}, 16'd0);
    check("flush_v1", regValue1, 16'h00FF);
    stall = 0; readAdd1 = 3; in_valid = 1; step();
    check("flush2_v1", regValue1, 16'h00FF);
    flush = 0; step();
    check("after_v1", regValue1, 16'h1234);
    check("after_valid", {15'd0, out_valid}, 16'd1);

    // reset during stall
    wr(4, 16'hAAAA);
    stall = 1; reset = 1; step();
    reset = 0;
    check("rst2_v1", regValue1, 16'h0000);
    check("rst2_valid", {15'd0, out_valid}, 16'd0);
    stall = 0; readAdd1 = 4; in_valid = 1; step();
    check("rst2_rd4", regValue1, 16'h0000);
    check("rst2_rel", {15'd0, out_valid}, 16'd1);

    // register 0 behaviour
    idle(); write = 1; writeAdd = 0; din = 16'h5555; readAdd1 = 0; in_valid = 1; step();
    check("r0_now", regValue1, R0Z ? 16'h0000 : 16'h5555);
    write = 0; step();
    check("r0_later", regValue1, R0Z ? 16'h0000 : 16'h5555);

    idle(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
